// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: operand width, FSM states
// and the full-adder cell used by the ripple subtractor.
package div_pkg;

    localparam int DIV_W = 8;
    localparam int CNT_W = $clog2(DIV_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Library full-adder cell, returned as {carry_out, sum}.
    function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

endpackage

// File: rtl/div8_seq_if.sv
// Start/result handshake bundle between a requester and the divider.
interface div8_seq_if #(parameter int W = div_pkg::DIV_W);

    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/csub_rc.sv
// Ripple conditional subtractor a - b computed as a + ~b + 1 through a chain
// of full-adder cells; borrow is the inverted final carry.
module csub_rc
    import div_pkg::*;
#(
    parameter int N = DIV_W + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] carry_s;

    assign carry_s[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        logic [1:0] fa_s;
        assign fa_s         = fa_cell(a[i], ~b[i], carry_s[i]);
        assign diff[i]      = fa_s[0];
        assign carry_s[i+1] = fa_s[1];
    end

    assign borrow = ~carry_s[N];

endmodule

// File: rtl/div8_seq.sv
// Restoring unsigned divider: one quotient bit per clock, one-cycle done pulse,
// divide-by-zero answered in a single cycle without entering RUN.
module div8_seq
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic        clk,
    input  logic        rst_n,
    div8_seq_if.slave   bus
);

    localparam int CW = $clog2(W + 1);

    state_t          state_r, state_nx;
    logic [CW-1:0]   cnt_r, cnt_nx;
    logic [W-1:0]    q_r, q_nx;
    logic [W-1:0]    d_r, d_nx;
    logic [W:0]      r_r, r_nx;
    logic            busy_r, busy_nx;
    logic            done_r, done_nx;
    logic [W-1:0]    quo_r, quo_nx;
    logic [W-1:0]    rem_r, rem_nx;
    logic            dbz_r, dbz_nx;

    logic [W:0]      r_sh_s;
    logic [W:0]      diff_s;
    logic            borrow_s;
    logic [W-1:0]    q_step_s;
    logic [W:0]      r_step_s;

    // Shift {R,Q} left; the top bit of R is always zero because R < D.
    assign r_sh_s = (r_r << 1) | {{W{1'b0}}, q_r[W-1]};

    csub_rc #(.N(W + 1)) u_csub (
        .a      (r_sh_s),
        .b      ({1'b0, d_r}),
        .diff   (diff_s),
        .borrow (borrow_s)
    );

    assign q_step_s = {q_r[W-2:0], ~borrow_s};
    assign r_step_s = borrow_s ? r_sh_s : diff_s;

    // Next-state and next-output logic for the IDLE/RUN controller.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        q_nx     = q_r;
        d_nx     = d_r;
        r_nx     = r_r;
        busy_nx  = busy_r;
        done_nx  = 1'b0;
        quo_nx   = quo_r;
        rem_nx   = rem_r;
        dbz_nx   = dbz_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != {W{1'b0}}) begin
                        q_nx     = bus.dividend;
                        d_nx     = bus.divisor;
                        r_nx     = {(W + 1){1'b0}};
                        cnt_nx   = CW'(W);
                        state_nx = RUN;
                        busy_nx  = 1'b1;
                        dbz_nx   = 1'b0;
                    end else begin
                        quo_nx  = {W{1'b1}};
                        rem_nx  = bus.dividend;
                        dbz_nx  = 1'b1;
                        done_nx = 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                q_nx   = q_step_s;
                r_nx   = r_step_s;
                cnt_nx = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    quo_nx   = q_step_s;
                    rem_nx   = r_step_s[W-1:0];
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            q_r     <= '0;
            d_r     <= '0;
            r_r     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            quo_r   <= '0;
            rem_r   <= '0;
            dbz_r   <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            q_r     <= q_nx;
            d_r     <= d_nx;
            r_r     <= r_nx;
            busy_r  <= busy_nx;
            done_r  <= done_nx;
            quo_r   <= quo_nx;
            rem_r   <= rem_nx;
            dbz_r   <= dbz_nx;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_div8_seq.sv
// Scoreboard bench for div8_seq: directed corner cases plus random operands
// checked against plain integer division.
module tb_div8_seq;

    localparam int W = 8;

    typedef struct {
        int q;
        int r;
        int dbz;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   compared;
    int   mismatched;
    exp_t sb[$];

    div8_seq_if #(.W(W)) bus ();

    div8_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to check latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse retires one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", int'(bus.quotient), e.q);
                check("remainder", int'(bus.remainder), e.r);
                check("div_by_zero", int'(bus.div_by_zero), e.dbz);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("busy_timeout", 1, 0);
    endtask

    task automatic do_op(input int a, input int b);
        exp_t e;
        logic [7:0] av;
        logic [7:0] bv;
        av = a[7:0];
        bv = b[7:0];
        wait_idle();
        bus.start    = 1'b1;
        bus.dividend = av;
        bus.divisor  = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (b == 0) begin
            e.q = (1 << W) - 1;
            e.r = a;
            e.dbz = 1;
            e.cyc = cyc;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 0;
            e.cyc = cyc + W;
        end
        sb.push_back(e);
        check("busy_after_start", int'(bus.busy), (b != 0) ? 1 : 0);
    endtask

    initial begin
        int n;
        cyc          = 0;
        compared     = 0;
        mismatched   = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_quotient", int'(bus.quotient), 0);
        check("rst_remainder", int'(bus.remainder), 0);
        check("rst_dbz", int'(bus.div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(100, 7);
        do_op(255, 1);
        do_op(5, 9);
        do_op(255, 255);
        do_op(0, 5);
        do_op(42, 0);
        @(negedge clk);
        check("dbz_busy_low", int'(bus.busy), 0);
        do_op(0, 0);

        // Start while busy must be ignored.
        do_op(200, 3);
        @(negedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        do_op(9, 2);
        check("held_quotient", int'(bus.quotient), 66);
        check("held_remainder", int'(bus.remainder), 2);

        // Reset in the middle of a division aborts it without done.
        do_op(100, 7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_quotient", int'(bus.quotient), 0);
        check("abort_remainder", int'(bus.remainder), 0);
        check("abort_dbz", int'(bus.div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_op(100, 7);

        for (int i = 0; i < 3000; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 31) == 0) ? 0 : int'($urandom_range(0, 255));
            do_op(a, b);
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
